// File: rtl/link_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : link_scheduler
//  Description : Round-robin scheduler for four sources sharing one serial
//                link. The winning source holds the link for FRAME_LEN
//                cycles, followed by a one-cycle GAP, before the next
//                arbitration in IDLE.
//  Ports       : clk      - clock, rising-edge active
//                rst      - synchronous active-high reset
//                req[3:0] - per-source transfer request
//                dst[7:0] - destination key of source i on dst[2i+1:2i]
//                gnt[3:0] - one-hot grant, 0 when the link is free
//                sKey     - sender-mux select (3 - winner)
//                rKey     - receiver-demux select (latched destination key)
//                link_en  - a frame bit is on the link
//                bit_idx  - current frame bit index
//                done     - one-cycle pulse after a completed frame
//                abort    - one-cycle pulse after a frame cut short
//  Revision    : 1.0 - initial release
// ============================================================================
module link_scheduler #(
   parameter int FRAME_LEN = 8
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [3:0] req,
   input  logic [7:0] dst,
   output logic [3:0] gnt,
   output logic [1:0] sKey,
   output logic [1:0] rKey,
   output logic       link_en,
   output logic [7:0] bit_idx,
   output logic       done,
   output logic       abort
);

   localparam logic [7:0] c_LAST_BIT = 8'(FRAME_LEN - 1);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_XFER = 2'd1,
      ST_GAP  = 2'd2
   } state_t;

   state_t     r_state;
   logic [1:0] r_ptr;
   logic [1:0] r_win;
   logic [3:0] r_gnt;
   logic [1:0] r_skey;
   logic [1:0] r_rkey;
   logic       r_link_en;
   logic [7:0] r_bit_idx;
   logic       r_done;
   logic       r_abort;

   logic       w_found;
   logic [1:0] w_winner;
   logic [1:0] w_idx;
   logic [1:0] w_dst_key;

   // Round-robin search starting at r_ptr and wrapping modulo 4.
   always_comb begin
      w_found  = 1'b0;
      w_winner = r_ptr;
      w_idx    = r_ptr;
      for (int k = 0; k < 4; k++) begin
         w_idx = r_ptr + 2'(k);
         if (!w_found && req[w_idx]) begin
            w_found  = 1'b1;
            w_winner = w_idx;
         end
      end
   end

   assign w_dst_key = dst[{w_winner, 1'b0} +: 2];

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state   <= ST_IDLE;
         r_ptr     <= 2'd0;
         r_win     <= 2'd0;
         r_gnt     <= 4'd0;
         r_skey    <= 2'd0;
         r_rkey    <= 2'd0;
         r_link_en <= 1'b0;
         r_bit_idx <= 8'd0;
         r_done    <= 1'b0;
         r_abort   <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               r_done  <= 1'b0;
               r_abort <= 1'b0;
               if (w_found) begin
                  r_state   <= ST_XFER;
                  r_win     <= w_winner;
                  r_gnt     <= 4'b0001 << w_winner;
                  r_skey    <= 2'd3 - w_winner;
                  r_rkey    <= w_dst_key;
                  r_link_en <= 1'b1;
                  r_bit_idx <= 8'd0;
               end
            end
            ST_XFER: begin
               // Reaching the last bit completes the frame even if the
               // request drops on that same cycle.
               if (r_bit_idx == c_LAST_BIT || !req[r_win]) begin
                  r_state   <= ST_GAP;
                  r_gnt     <= 4'd0;
                  r_link_en <= 1'b0;
                  r_bit_idx <= 8'd0;
                  r_ptr     <= r_win + 2'd1;
                  r_done    <= (r_bit_idx == c_LAST_BIT);
                  r_abort   <= (r_bit_idx != c_LAST_BIT);
               end else begin
                  r_bit_idx <= r_bit_idx + 8'd1;
               end
            end
            ST_GAP: begin
               r_state <= ST_IDLE;
               r_done  <= 1'b0;
               r_abort <= 1'b0;
            end
            default: begin
               r_state   <= ST_IDLE;
               r_gnt     <= 4'd0;
               r_link_en <= 1'b0;
               r_bit_idx <= 8'd0;
               r_done    <= 1'b0;
               r_abort   <= 1'b0;
            end
         endcase
      end
   end

   assign gnt     = r_gnt;
   assign sKey    = r_skey;
   assign rKey    = r_rkey;
   assign link_en = r_link_en;
   assign bit_idx = r_bit_idx;
   assign done    = r_done;
   assign abort   = r_abort;

endmodule
`default_nettype wire

// File: tb/tb_link_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : tb_link_scheduler
//  Description : Directed testbench for link_scheduler (FRAME_LEN = 8).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_link_scheduler;

   logic       clk;
   logic       rst;
   logic [3:0] req;
   logic [7:0] dst;
   logic [3:0] gnt;
   logic [1:0] sKey;
   logic [1:0] rKey;
   logic       link_en;
   logic [7:0] bit_idx;
   logic       done;
   logic       abort;

   int checks = 0;
   int errors = 0;

   link_scheduler #(.FRAME_LEN(8)) dut (
      .clk     (clk),
      .rst     (rst),
      .req     (req),
      .dst     (dst),
      .gnt     (gnt),
      .sKey    (sKey),
      .rKey    (rKey),
      .link_en (link_en),
      .bit_idx (bit_idx),
      .done    (done),
      .abort   (abort)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic check_idle_outputs(input string tag);
      check({tag, " gnt"},     gnt,     4'd0);
      check({tag, " link_en"}, link_en, 1'b0);
      check({tag, " bit_idx"}, bit_idx, 8'd0);
      check({tag, " done"},    done,    1'b0);
      check({tag, " abort"},   abort,   1'b0);
   endtask

   initial begin
      rst = 1'b1;
      req = 4'd0;
      dst = 8'd0;
      tick();
      tick();
      // Reset state
      check_idle_outputs("reset");
      check("reset sKey", sKey, 2'd0);
      check("reset rKey", rKey, 2'd0);

      // Single request from source 2, dst[5:4] = 01
      rst = 1'b0;
      req = 4'b0100;
      dst = 8'b0001_0000;
      tick();
      check("single gnt",  gnt,  4'b0100);
      check("single sKey", sKey, 2'b01);
      check("single rKey", rKey, 2'b01);
      for (int b = 0; b < 8; b++) begin
         check("single bit_idx", bit_idx, 32'(b));
         check("single link_en", link_en, 1'b1);
         check("single gnt hold", gnt, 4'b0100);
         tick();
      end
      check("single done",    done,    1'b1);
      check("single abort",   abort,   1'b0);
      check("single gap gnt", gnt,     4'd0);
      check("single gap link_en", link_en, 1'b0);
      check("single sKey hold", sKey,  2'b01);
      check("single rKey hold", rKey,  2'b01);
      req = 4'd0;
      tick();
      check_idle_outputs("single idle");
      tick();
      check_idle_outputs("single stay idle");

      // Fairness: all four requesting from reset
      rst = 1'b1;
      tick();
      rst = 1'b0;
      req = 4'b1111;
      dst = 8'b01_11_00_10;
      for (int n = 0; n < 5; n++) begin
         int w;
         logic [7:0] d;
         w = n % 4;
         d = dst >> (2 * w);
         tick();
         check("fair gnt",  gnt,  4'b0001 << w);
         check("fair sKey", sKey, 32'(3 - w));
         check("fair rKey", rKey, {30'd0, d[1:0]});
         for (int b = 1; b < 8; b++) tick();
         check("fair last bit", bit_idx, 8'd7);
         check("fair last gnt", gnt, 4'b0001 << w);
         tick();
         check("fair done", done, 1'b1);
         check("fair gap gnt", gnt, 4'd0);
         tick();
         check_idle_outputs("fair idle");
      end

      // Abort: source 1 drops its request at bit 3
      rst = 1'b1;
      req = 4'b0010;
      tick();
      rst = 1'b0;
      tick();
      check("abort gnt", gnt, 4'b0010);
      tick();
      tick();
      tick();
      check("abort bit3", bit_idx, 8'd3);
      req = 4'd0;
      tick();
      check("abort pulse", abort, 1'b1);
      check("abort done", done, 1'b0);
      check("abort gnt clr", gnt, 4'd0);
      check("abort link_en", link_en, 1'b0);
      check("abort bit_idx", bit_idx, 8'd0);
      req = 4'b0011;
      dst = 8'b0000_0010;
      tick();
      check_idle_outputs("abort gap->idle");
      tick();
      check("abort next gnt", gnt, 4'b0001);

      // Destination latch during the source-0 frame
      check("latch rKey start", rKey, 2'b10);
      dst = 8'b0000_0011;
      for (int b = 1; b < 8; b++) begin
         tick();
         check("latch bit_idx", bit_idx, 32'(b));
         check("latch rKey", rKey, 2'b10);
      end
      tick();
      check("latch done", done, 1'b1);
      check("latch rKey gap", rKey, 2'b10);
      tick();
      tick();
      check("rr gnt src1", gnt, 4'b0010);
      check("rr rKey src1", rKey, 2'b00);

      // Reset mid-frame at bit 4
      tick();
      tick();
      tick();
      tick();
      check("rstmid bit4", bit_idx, 8'd4);
      rst = 1'b1;
      req = 4'b1000;
      dst = 8'b10_00_00_11;
      tick();
      check_idle_outputs("rstmid");
      check("rstmid sKey", sKey, 2'd0);
      check("rstmid rKey", rKey, 2'd0);
      tick();
      check_idle_outputs("rst held");
      rst = 1'b0;
      tick();
      check("post-rst gnt",  gnt,  4'b1000);
      check("post-rst sKey", sKey, 2'b00);
      check("post-rst rKey", rKey, 2'b10);
      check("post-rst link_en", link_en, 1'b1);

      // Last-bit drop: source 2 releases exactly at bit 7
      rst = 1'b1;
      tick();
      rst = 1'b0;
      req = 4'b0100;
      tick();
      check("lastdrop gnt", gnt, 4'b0100);
      for (int b = 1; b < 8; b++) tick();
      check("lastdrop bit7", bit_idx, 8'd7);
      req = 4'd0;
      tick();
      check("lastdrop done", done, 1'b1);
      check("lastdrop abort", abort, 1'b0);
      tick();
      check_idle_outputs("lastdrop idle");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
